// File: rtl/gpreg_load_unit_pkg.sv
// Shared definitions for the GPReg memory-load sequencer: GPReg command
// encodings, register-index and data widths, and the sequencer state type.
package gpreg_load_unit_pkg;

    localparam int GPREG_IDX_W  = 3;
    localparam int GPREG_DATA_W = 32;

    localparam logic [1:0] GPREG_CMD_NOP   = 2'b00;
    localparam logic [1:0] GPREG_CMD_WRITE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2
    } load_state_t;

endpackage

// File: rtl/gpreg_load_timer.sv
// Ack-wait timer: counts consecutive ISSUE cycles and flags the last allowed
// one. Only instantiated when MEM_LOAD_TIMEOUT_EN is defined.
module gpreg_load_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;

    // Holds the number of ISSUE cycles already spent, so it reads k-1 in the
    // k-th cycle; any cycle outside ISSUE clears it for the next word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= '0;
        end
    end

    assign o_expired = i_run && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/gpreg_load_unit.sv
// Memory-load sequencer: reads a burst of words over req/ack and writes them
// into consecutive GP registers. Optional ack timeout: MEM_LOAD_TIMEOUT_EN.
module gpreg_load_unit
    import gpreg_load_unit_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = GPREG_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [GPREG_IDX_W-1:0] req_reg,
    input  logic [2:0]             req_cnt,
    output logic                   mem_rd_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_rd_ack,
    input  logic [DATA_W-1:0]      mem_rd_data,
    output logic [GPREG_IDX_W-1:0] SelZ,
    output logic [1:0]             MemInstruction,
    output logic [DATA_W-1:0]      MemData,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    load_state_t            r_state;
    load_state_t            w_next;
    logic [ADDR_W-1:0]      r_cur_addr;
    logic [GPREG_IDX_W-1:0] r_cur_reg;
    logic [2:0]             r_remaining;
    logic [DATA_W-1:0]      r_data;
    logic                   w_in_issue;
    logic                   w_in_wb;
    logic                   w_timeout;

    assign w_in_issue = (r_state == ST_ISSUE);
    assign w_in_wb    = (r_state == ST_WB);

`ifdef MEM_LOAD_TIMEOUT_EN
    gpreg_load_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_run     (w_in_issue),
        .o_expired (w_timeout)
    );
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign w_timeout            = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The timeout cycle wins over a late ack: the request is already dropped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_timeout) begin
                    w_next = ST_IDLE;
                end else if (mem_rd_ack) begin
                    w_next = ST_WB;
                end
            end
            ST_WB: begin
                w_next = (r_remaining == 3'd0) ? ST_IDLE : ST_ISSUE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Datapath registers need no reset: every output using them is gated by state.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && req_valid) begin
            r_cur_addr  <= req_addr;
            r_cur_reg   <= req_reg;
            r_remaining <= req_cnt;
        end else if (w_in_wb && r_remaining != 3'd0) begin
            r_cur_addr  <= r_cur_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            r_cur_reg   <= r_cur_reg + {{(GPREG_IDX_W-1){1'b0}}, 1'b1};
            r_remaining <= r_remaining - 3'd1;
        end
        if (w_in_issue && mem_rd_ack && !w_timeout) begin
            r_data <= mem_rd_data;
        end
    end

    assign req_ready      = (r_state == ST_IDLE);
    assign busy           = w_in_issue || w_in_wb;
    assign mem_rd_req     = w_in_issue && !w_timeout;
    assign mem_addr       = w_in_issue ? r_cur_addr : '0;
    assign SelZ           = w_in_wb ? r_cur_reg : '0;
    assign MemInstruction = w_in_wb ? GPREG_CMD_WRITE : GPREG_CMD_NOP;
    assign MemData        = w_in_wb ? r_data : '0;
    assign done           = w_in_wb && (r_remaining == 3'd0);
    assign err            = w_timeout;

endmodule
